pipeline_stall_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage MIPS pipeline. Merges the load-use hazard indication, branch-taken redirect and multi-cycle data-memory handshake into one prioritized set of per-stage enables, flushes and bubble selects. Also sequences the end of program: on a halt instruction in ID it drains the pipeline, then parks in a halted state. Sits beside the hazard detection unit and drives the PC, IF/ID, ID/EX control mux, EX/MEM and MEM/WB registers.

---
 rtl/pipeline_stall_ctrl_pkg.sv | 28 ++
 rtl/pipeline_stall_ctrl_if.sv | 29 ++
 rtl/pipeline_stall_ctrl_perf_counters.sv | 36 +++
 rtl/pipeline_stall_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// STALL_PERF_COUNTERS_EN enables the optional performance counters.
package pipeline_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } ctrlState_e;

    localparam int DEFAULT_DRAIN_CYCLES = 3;
    localparam int DEFAULT_MEM_TIMEOUT  = 255;
    localparam int PERF_CNT_W           = 32;

    // Saturating increment used by the event counters.
    function automatic logic [PERF_CNT_W-1:0] satInc(
        input logic [PERF_CNT_W-1:0] value,
        input logic                  enable
    );
        if (enable && (value != {PERF_CNT_W{1'b1}})) begin
            return value + {{(PERF_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard/handshake inputs and per-stage control outputs of the stall sequencer.
// The controller uses the slave modport; the pipeline side uses master.
interface pipeline_stall_ctrl_if;
    logic load_use_stall;
    logic branch_takenD;
    logic halt_instrD;
    logic mem_reqM;
    logic mem_readyM;
    logic pc_enable;
    logic ifid_enable;
    logic ifid_flush;
    logic idex_ctrl_sel;
    logic exmem_enable;
    logic memwb_enable;
    logic halted;
    logic mem_error;

    modport slave (
        input  load_use_stall, branch_takenD, halt_instrD, mem_reqM, mem_readyM,
        output pc_enable, ifid_enable, ifid_flush, idex_ctrl_sel,
               exmem_enable, memwb_enable, halted, mem_error
    );

    modport master (
        output load_use_stall, branch_takenD, halt_instrD, mem_reqM, mem_readyM,
        input  pc_enable, ifid_enable, ifid_flush, idex_ctrl_sel,
               exmem_enable, memwb_enable, halted, mem_error
    );
endinterface

// File: rtl/pipeline_stall_ctrl_perf_counters.sv
// Saturating stall/flush/memory-wait event counters, present only when
// STALL_PERF_COUNTERS_EN is defined.
`ifdef STALL_PERF_COUNTERS_EN
module stall_perf_counters
    import pipeline_stall_ctrl_pkg::*;
(
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  freeze,
    input  logic                  stallEvt,
    input  logic                  flushEvt,
    input  logic                  memWaitEvt,
    output logic [PERF_CNT_W-1:0] stall_cycles,
    output logic [PERF_CNT_W-1:0] flush_count,
    output logic [PERF_CNT_W-1:0] mem_wait_cycles
);

    // Event counters: cleared by reset, held while the pipeline is halted.
    always_ff @(posedge CLK) begin
        if (reset) begin
            stall_cycles    <= {PERF_CNT_W{1'b0}};
            flush_count     <= {PERF_CNT_W{1'b0}};
            mem_wait_cycles <= {PERF_CNT_W{1'b0}};
        end else if (freeze) begin
            stall_cycles    <= stall_cycles;
            flush_count     <= flush_count;
            mem_wait_cycles <= mem_wait_cycles;
        end else begin
            stall_cycles    <= satInc(stall_cycles, stallEvt);
            flush_count     <= satInc(flush_count, flushEvt);
            mem_wait_cycles <= satInc(mem_wait_cycles, memWaitEvt);
        end
    end

endmodule
`endif

// File: rtl/pipeline_stall_ctrl.sv
// Prioritized stall/flush/bubble sequencer with halt drain and memory timeout.
// Define STALL_PERF_COUNTERS_EN to add the stall/flush/mem-wait counters.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
    parameter int MEM_TIMEOUT  = DEFAULT_MEM_TIMEOUT
) (
    input  logic                  CLK,
    input  logic                  reset,
    pipeline_stall_ctrl_if.slave  bus
`ifdef STALL_PERF_COUNTERS_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cycles,
    output logic [PERF_CNT_W-1:0] flush_count,
    output logic [PERF_CNT_W-1:0] mem_wait_cycles
`endif
);

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD  = DRAIN_W'(DRAIN_CYCLES);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE   = DRAIN_W'(1);
    localparam logic [WAIT_W:0]    TIMEOUT_CMP = (WAIT_W + 1)'(MEM_TIMEOUT);
    localparam logic [WAIT_W:0]    WAIT_ONE    = (WAIT_W + 1)'(1);

    ctrlState_e         state_r, nextState_s;
    logic [DRAIN_W-1:0] drainCnt_r, nextDrain_s;
    logic [WAIT_W-1:0]  waitCnt_r, nextWait_s;
    logic [WAIT_W:0]    waitInc_s;
    logic               memErr_r, nextErr_s;
    logic               memStall_s;
    logic pcEn_s, ifidEn_s, flush_s, idexSel_s, exmemEn_s, memwbEn_s, halted_s, memErrOut_s;

    assign memStall_s = bus.mem_reqM & ~bus.mem_readyM;
    assign waitInc_s  = {1'b0, waitCnt_r} + WAIT_ONE;

    // Next-state and stage controls, resolved in priority order.
    always_comb begin
        pcEn_s      = 1'b1;
        ifidEn_s    = 1'b1;
        flush_s     = 1'b0;
        idexSel_s   = 1'b1;
        exmemEn_s   = 1'b1;
        memwbEn_s   = 1'b1;
        halted_s    = 1'b0;
        memErrOut_s = memErr_r;
        nextState_s = state_r;
        nextDrain_s = drainCnt_r;
        nextWait_s  = {WAIT_W{1'b0}};
        nextErr_s   = memErr_r;
        if (reset) begin
            pcEn_s      = 1'b0;
            ifidEn_s    = 1'b0;
            idexSel_s   = 1'b0;
            exmemEn_s   = 1'b0;
            memwbEn_s   = 1'b0;
            memErrOut_s = 1'b0;
        end else if (state_r == HALTED) begin
            pcEn_s    = 1'b0;
            ifidEn_s  = 1'b0;
            idexSel_s = 1'b0;
            exmemEn_s = 1'b0;
            memwbEn_s = 1'b0;
            halted_s  = 1'b1;
        end else if (memStall_s) begin
            pcEn_s    = 1'b0;
            ifidEn_s  = 1'b0;
            exmemEn_s = 1'b0;
            memwbEn_s = 1'b0;
            if (waitInc_s == TIMEOUT_CMP) begin
                nextErr_s   = 1'b1;
                nextState_s = HALTED;
            end else begin
                nextWait_s  = waitInc_s[WAIT_W-1:0];
                nextState_s = (state_r == DRAIN) ? DRAIN : MEM_WAIT;
            end
        end else if (state_r == DRAIN) begin
            pcEn_s      = 1'b0;
            ifidEn_s    = 1'b0;
            idexSel_s   = 1'b0;
            nextDrain_s = drainCnt_r - DRAIN_ONE;
            nextState_s = (drainCnt_r == DRAIN_ONE) ? HALTED : DRAIN;
        end else if (bus.load_use_stall) begin
            // Branch and halt are deliberately ignored until the stall clears.
            pcEn_s      = 1'b0;
            ifidEn_s    = 1'b0;
            idexSel_s   = 1'b0;
            nextState_s = RUN;
        end else if (bus.halt_instrD) begin
            pcEn_s      = 1'b0;
            flush_s     = 1'b1;
            nextDrain_s = DRAIN_LOAD;
            nextState_s = DRAIN;
        end else if (bus.branch_takenD) begin
            flush_s     = 1'b1;
            nextState_s = RUN;
        end else begin
            nextState_s = RUN;
        end
    end

    // Sequencer state, drain/wait counters and sticky memory error.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_r    <= RUN;
            drainCnt_r <= {DRAIN_W{1'b0}};
            waitCnt_r  <= {WAIT_W{1'b0}};
            memErr_r   <= 1'b0;
        end else begin
            state_r    <= nextState_s;
            drainCnt_r <= nextDrain_s;
            waitCnt_r  <= nextWait_s;
            memErr_r   <= nextErr_s;
        end
    end

    assign bus.pc_enable     = pcEn_s;
    assign bus.ifid_enable   = ifidEn_s;
    assign bus.ifid_flush    = flush_s;
    assign bus.idex_ctrl_sel = idexSel_s;
    assign bus.exmem_enable  = exmemEn_s;
    assign bus.memwb_enable  = memwbEn_s;
    assign bus.halted        = halted_s;
    assign bus.mem_error     = memErrOut_s;

`ifdef STALL_PERF_COUNTERS_EN
    logic stallEvt_s, memWaitEvt_s, frozen_s;

    assign frozen_s     = (state_r == HALTED);
    assign stallEvt_s   = ~reset & ((state_r == RUN) | (state_r == MEM_WAIT))
                          & ~memStall_s & bus.load_use_stall;
    assign memWaitEvt_s = ~reset & ~frozen_s & memStall_s;

    stall_perf_counters u_perf (
        .CLK             (CLK),
        .reset           (reset),
        .freeze          (frozen_s),
        .stallEvt        (stallEvt_s),
        .flushEvt        (flush_s),
        .memWaitEvt      (memWaitEvt_s),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count),
        .mem_wait_cycles (mem_wait_cycles)
    );
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: directed test-plan sequences
// followed by random traffic, checked against a rule-level reference model.
`timescale 1ns/1ps
module tb_pipeline_stall_ctrl;
    import pipeline_stall_ctrl_pkg::*;

    localparam int DC = 3;
    localparam int MT = 6;

    typedef struct {
        int          cyc;
        logic [7:0]  sig;   // {pc, ifidEn, flush, idexSel, exmem, memwb, halted, memErr}
        int unsigned st;
        int unsigned fl;
        int unsigned mw;
    } exp_t;

    logic CLK = 1'b0;
    logic reset = 1'b1;
    always #5 CLK = ~CLK;

    pipeline_stall_ctrl_if bus();

`ifdef STALL_PERF_COUNTERS_EN
    logic [31:0] stallCycles, flushCount, memWaitCycles;
`endif

    pipeline_stall_ctrl #(.DRAIN_CYCLES(DC), .MEM_TIMEOUT(MT)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
`ifdef STALL_PERF_COUNTERS_EN
        ,
        .stall_cycles    (stallCycles),
        .flush_count     (flushCount),
        .mem_wait_cycles (memWaitCycles)
`endif
    );

    exp_t expQ[$];
    int   total = 0;
    int   bad = 0;
    int   cycle = 0;
    bit   stimDone = 1'b0;

    // Reference model: 0 = running, 1 = draining, 2 = halted.
    int          mMode = 0;
    int          mDrainLeft = 0;
    int          mWaitRun = 0;
    bit          mErr = 1'b0;
    int unsigned mStall = 0, mFlush = 0, mMemWait = 0;

    task automatic step(input bit lu, input bit br, input bit ht,
                        input bit rq, input bit rd, input bit rst);
        exp_t e;
        @(posedge CLK);
        #1;
        cycle++;
        reset              = rst;
        bus.load_use_stall = lu;
        bus.branch_takenD  = br;
        bus.halt_instrD    = ht;
        bus.mem_reqM       = rq;
        bus.mem_readyM     = rd;
        e.cyc = cycle;
        e.st  = mStall;
        e.fl  = mFlush;
        e.mw  = mMemWait;
        if (rst) begin
            e.sig = 8'b0000_0000;
            mMode = 0; mDrainLeft = 0; mWaitRun = 0; mErr = 1'b0;
            mStall = 0; mFlush = 0; mMemWait = 0;
        end else if (mMode == 2) begin
            e.sig = {7'b000_0001, mErr};
        end else if (rq && !rd) begin
            e.sig = {7'b000_1000, mErr};
            mMemWait++;
            mWaitRun++;
            if (mWaitRun == MT) begin
                mErr  = 1'b1;
                mMode = 2;
            end
        end else begin
            mWaitRun = 0;
            if (mMode == 1) begin
                e.sig = {7'b000_0110, mErr};
                mDrainLeft--;
                if (mDrainLeft == 0) mMode = 2;
            end else if (lu) begin
                e.sig = {7'b000_0110, mErr};
                mStall++;
            end else if (ht) begin
                e.sig = {7'b011_1110, mErr};
                mFlush++;
                mMode = 1;
                mDrainLeft = DC;
            end else if (br) begin
                e.sig = {7'b111_1110, mErr};
                mFlush++;
            end else begin
                e.sig = {7'b110_1110, mErr};
            end
        end
        expQ.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic runStimulus();
        int haltCnt = 0;
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        idle(2);
        // single load-use stall
        step(1, 0, 0, 0, 0, 0);
        idle(1);
        // stall masks branch, branch flushes next cycle
        step(1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        idle(1);
        // four memory wait cycles then completion
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        idle(1);
        // halt with concurrent branch, drain, stay halted
        step(0, 1, 1, 0, 0, 0);
        idle(DC + 3);
        step(0, 0, 0, 0, 0, 1);
        // memory timeout, then reset clears error
        for (int i = 0; i < MT + 2; i++) step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 1);
        idle(1);
        // memory stall in the middle of a drain
        step(0, 0, 1, 0, 0, 0);
        idle(1);
        step(0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        idle(DC + 2);
        // reset in the middle of a drain
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 1);
        idle(2);
        // counter scenario: 2 stalls, 1 flush, 3 memory waits
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        idle(2);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bit rst;
            haltCnt = (mMode == 2) ? haltCnt + 1 : 0;
            rst = ($urandom_range(0, 99) < 1) || (haltCnt > 3);
            step($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 60, rst);
        end
        stimDone = 1'b1;
    endtask

    task automatic runMonitor();
        int waitCycles = 0;
        while (!(stimDone && expQ.size() == 0)) begin
            @(negedge CLK);
            if (expQ.size() > 0) begin
                exp_t e;
                logic [7:0] act;
                e = expQ.pop_front();
                act = {bus.pc_enable, bus.ifid_enable, bus.ifid_flush, bus.idex_ctrl_sel,
                       bus.exmem_enable, bus.memwb_enable, bus.halted, bus.mem_error};
                total++;
                if (act !== e.sig) begin
                    bad++;
                    $display("FAIL ctrl_outputs cycle=%0d got=%b expected=%b", e.cyc, act, e.sig);
                end
`ifdef STALL_PERF_COUNTERS_EN
                total++;
                if (stallCycles !== e.st || flushCount !== e.fl || memWaitCycles !== e.mw) begin
                    bad++;
                    $display("FAIL perf_counters cycle=%0d got=%0d/%0d/%0d expected=%0d/%0d/%0d",
                             e.cyc, stallCycles, flushCount, memWaitCycles, e.st, e.fl, e.mw);
                end
`endif
            end else if (stimDone) begin
                waitCycles++;
                if (waitCycles > 20) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard_drain got=%0d pending expected=0", expQ.size());
                    break;
                end
            end
        end
    endtask

    initial begin
        bus.load_use_stall = 1'b0;
        bus.branch_takenD  = 1'b0;
        bus.halt_instrD    = 1'b0;
        bus.mem_reqM       = 1'b0;
        bus.mem_readyM     = 1'b0;
        fork
            runStimulus();
            runMonitor();
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
